decm: RTL and testbench
=======================

# decm

Instruction decode register stage of the k11 RV32I pipeline, directly downstream of the fetch stage. It accepts the fetched PC and raw instruction word over a valid/ready handshake, decodes the RV32I fields, builds the sign-extended immediate, and classifies the instruction. All results are registered for the execute stage. It also drives the register-file read addresses combinationally from the incoming word, so a synchronous-read register file returns operands aligned with the registered outputs.

## Interface
- No parameters.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  reset; **asynchronous, active-low**.
- valid_i  in  1  fetch stage holds a valid instruction.
- ready_o  out  1  decm accepts this cycle; wired to the fetch stage's ready input.
- pc_i  in  32  PC of the incoming instruction.
- inst_i  in  32  raw instruction word.
- jump_taken_i  in  1  redirect from execute; squashes the incoming instruction.
- rs1addr_o  out  5  inst_i[19:15], combinational.
- rs2addr_o  out  5  inst_i[24:20], combinational.
- valid_ro  out  1  registered: decoded instruction present.
- ready_i  in  1  execute stage accepts.
- pc_ro  out  32  registered PC.
- inst_ro  out  32  registered raw word.
- rd_ro, rs1_ro, rs2_ro  out  5 each  registered register indices.
- funct3_ro  out  3  inst[14:12].
- funct7b5_ro  out  1  inst[30].
- imm_ro  out  32  sign-extended immediate.
- class_ro  out  4  instruction class (encoding below).
- rd_we_ro  out  1  instruction writes rd.

## Operation
- Capture enable: cke = ~valid_ro | ready_i | jump_taken_i; ready_o = cke.
- On cke:
  - valid_ro <= valid_i & ~jump_taken_i.
  - Every other registered field loads its decode of inst_i/pc_i, whether or not valid_i is high.
- Without cke, all registered outputs hold.
- Fields are meaningful only while valid_ro = 1.
- class encoding:
  - 0 OP, 1 OP-IMM, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 MISC-MEM, 10 SYSTEM, 15 ILLEGAL.
  - 11–14 are never produced.
- ILLEGAL when any of the following holds:
  - inst[1:0] != 2'b11.
  - Opcode outside the eleven listed.
  - JALR with funct3 != 000.
  - BRANCH with funct3 010 or 011.
  - LOAD with funct3 011, 110 or 111.
  - STORE with funct3[2] = 1 or funct3 = 011.
  - OP-IMM funct3 001 with inst[31:25] != 0.
  - OP-IMM funct3 101 with inst[31:25] not 0000000 and not 0100000.
  - OP with inst[31:25] not 0000000, and not 0100000 with funct3 000/101.
- Immediate (inst = I), all sign-extended from I[31]:
  - I-type: I[31:20].
  - S-type: {I[31:25], I[11:7]}.
  - B-type: {I[31], I[7], I[30:25], I[11:8], 0}.
  - U-type: {I[31:12], 12'b0}.
  - J-type: {I[31], I[19:12], I[20], I[30:21], 0}.
  - OP, MISC-MEM and ILLEGAL: imm = 0.
  - SYSTEM: I-type immediate.
- rd_we_ro = 1 iff class ∈ {0, 1, 2, 5, 6, 7, 8} and rd != 0.

## Timing
- Latency: 1 cycle from the inst_i/valid_i capture edge to valid_ro.
- Full throughput: one instruction per cycle while ready_i = 1.
- Reset: all registered outputs are 0, including class_ro = 0 and valid_ro = 0. This holds immediately on rst_n low, independent of clk.
- Reset mid-operation discards the held instruction. First capture is on the first edge after rst_n rises.
- Stall: with valid_ro = 1 and ready_i = 0, ready_o = 0 and outputs hold indefinitely.
- Stall with jump_taken_i = 1: cke forces capture and valid_ro becomes 0.
- jump_taken_i and valid_i high together: the instruction is squashed and never appears valid.
- Bubble: valid_i = 0 with cke gives valid_ro = 0 on the next edge.
- rs1addr_o and rs2addr_o track inst_i every cycle, including during stalls.

## Test plan
- Reset with inst_i = 0x00500093 and valid_i = 1:
  - Before the first edge: all outputs 0, valid_ro = 0.
  - After: valid_ro = 1, class = 1, rd = 1, rs1 = 0, imm = 0x00000005, rd_we = 1.
- Back-to-back 0xFE20AE23, 0xFE000CE3, 0x123452B7 with ready_i = 1. On consecutive cycles:
  - sw x2,-4(x1): class = 3, rs1 = 1, rs2 = 2, imm = 0xFFFFFFFC, rd_we = 0.
  - beq x0,x0,-8: class = 4, imm = 0xFFFFFFF8.
  - lui x5: class = 7, rd = 5, imm = 0x12345000, rd_we = 1.
- Illegal words:
  - 0x00000000 → class 15, rd_we 0, imm 0.
  - 0x40001013 (slli, funct7 bad) → class 15.
  - 0x40000033 (sub) → class 0, funct7b5 = 1.
- Stall: ready_i = 0 for 5 cycles with valid_ro = 1.
  - ready_o = 0 and outputs frozen.
  - rs1addr_o follows changing inst_i.
  - Release → the next instruction is captured on the following edge.
- Flush: jump_taken_i = 1 in the same cycle as valid_i = 1 during a stall → next cycle valid_ro = 0 and ready_o = 1 during the flush cycle.
- Async reset asserted mid-stream between clock edges → valid_ro and all fields go to 0 immediately, with no instruction re-emitted afterwards.

Source files
------------

// File: rtl/decm.sv
// decm: RV32I decode register stage.
// Decodes fetched words and registers fields for execute.
module decm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  input  logic        jump_taken_i,
  output logic [4:0]  rs1addr_o,
  output logic [4:0]  rs2addr_o,
  output logic        valid_ro,
  input  logic        ready_i,
  output logic [31:0] pc_ro,
  output logic [31:0] inst_ro,
  output logic [4:0]  rd_ro,
  output logic [4:0]  rs1_ro,
  output logic [4:0]  rs2_ro,
  output logic [2:0]  funct3_ro,
  output logic        funct7b5_ro,
  output logic [31:0] imm_ro,
  output logic [3:0]  class_ro,
  output logic        rd_we_ro
);

  localparam logic [6:0] OPC_OP   = 7'b0110011;
  localparam logic [6:0] OPC_IMM  = 7'b0010011;
  localparam logic [6:0] OPC_LD   = 7'b0000011;
  localparam logic [6:0] OPC_ST   = 7'b0100011;
  localparam logic [6:0] OPC_BR   = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_LUI  = 7'b0110111;
  localparam logic [6:0] OPC_AUI  = 7'b0010111;
  localparam logic [6:0] OPC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_SYS  = 7'b1110011;

  logic        cke;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd;
  logic [3:0]  cls;
  logic [31:0] imm;
  logic        we;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign cke       = ~valid_ro | ready_i | jump_taken_i;
  assign ready_o   = cke;
  assign rs1addr_o = inst_i[19:15];
  assign rs2addr_o = inst_i[24:20];

  assign opc = inst_i[6:0];
  assign f3  = inst_i[14:12];
  assign f7  = inst_i[31:25];
  assign rd  = inst_i[11:7];

  assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25],
                  inst_i[11:8], 1'b0};
  assign imm_u = {inst_i[31:12], 12'b0};
  assign imm_j = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20],
                  inst_i[30:21], 1'b0};

  // Classify the opcode, demoting bad funct3/funct7 combos to ILLEGAL
  always_comb begin
    cls = 4'd15;
    unique case (opc)
      OPC_OP: begin
        if (f7 == 7'h00 ||
            (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)))
          cls = 4'd0;
      end
      OPC_IMM: begin
        if ((f3 != 3'b001 || f7 == 7'h00) &&
            (f3 != 3'b101 || f7 == 7'h00 || f7 == 7'h20))
          cls = 4'd1;
      end
      OPC_LD: begin
        if (f3 != 3'b011 && f3[2:1] != 2'b11)
          cls = 4'd2;
      end
      OPC_ST: begin
        if (!f3[2] && f3 != 3'b011)
          cls = 4'd3;
      end
      OPC_BR: begin
        if (f3[2:1] != 2'b01)
          cls = 4'd4;
      end
      OPC_JAL:  cls = 4'd5;
      OPC_JALR: begin
        if (f3 == 3'b000)
          cls = 4'd6;
      end
      OPC_LUI:  cls = 4'd7;
      OPC_AUI:  cls = 4'd8;
      OPC_MEM:  cls = 4'd9;
      OPC_SYS:  cls = 4'd10;
      default:  cls = 4'd15;
    endcase
  end

  // Pick the immediate format and rd write enable from the class
  always_comb begin
    imm = 32'b0;
    we  = 1'b0;
    unique case (cls)
      4'd0:  we  = 1'b1;
      4'd1:  begin imm = imm_i; we = 1'b1; end
      4'd2:  begin imm = imm_i; we = 1'b1; end
      4'd3:  imm = imm_s;
      4'd4:  imm = imm_b;
      4'd5:  begin imm = imm_j; we = 1'b1; end
      4'd6:  begin imm = imm_i; we = 1'b1; end
      4'd7:  begin imm = imm_u; we = 1'b1; end
      4'd8:  begin imm = imm_u; we = 1'b1; end
      4'd10: imm = imm_i;
      default: begin
        imm = 32'b0;
        we  = 1'b0;
      end
    endcase
    if (rd == 5'd0)
      we = 1'b0;
  end

  // Pipeline register toward execute; a redirect squashes the capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_ro    <= 1'b0;
      pc_ro       <= 32'b0;
      inst_ro     <= 32'b0;
      rd_ro       <= 5'b0;
      rs1_ro      <= 5'b0;
      rs2_ro      <= 5'b0;
      funct3_ro   <= 3'b0;
      funct7b5_ro <= 1'b0;
      imm_ro      <= 32'b0;
      class_ro    <= 4'b0;
      rd_we_ro    <= 1'b0;
    end else if (cke) begin
      valid_ro    <= valid_i & ~jump_taken_i;
      pc_ro       <= pc_i;
      inst_ro     <= inst_i;
      rd_ro       <= rd;
      rs1_ro      <= inst_i[19:15];
      rs2_ro      <= inst_i[24:20];
      funct3_ro   <= f3;
      funct7b5_ro <= inst_i[30];
      imm_ro      <= imm;
      class_ro    <= cls;
      rd_we_ro    <= we;
    end
  end

endmodule

// File: tb/tb_decm.sv
// tb_decm: randomized scoreboard bench for decm.
// Reference decode model lives in the bench.
module tb_decm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic        jump_taken_i;
  logic [4:0]  rs1addr_o;
  logic [4:0]  rs2addr_o;
  logic        valid_ro;
  logic        ready_i;
  logic [31:0] pc_ro;
  logic [31:0] inst_ro;
  logic [4:0]  rd_ro;
  logic [4:0]  rs1_ro;
  logic [4:0]  rs2_ro;
  logic [2:0]  funct3_ro;
  logic        funct7b5_ro;
  logic [31:0] imm_ro;
  logic [3:0]  class_ro;
  logic        rd_we_ro;

  decm dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .pc_i         (pc_i),
    .inst_i       (inst_i),
    .jump_taken_i (jump_taken_i),
    .rs1addr_o    (rs1addr_o),
    .rs2addr_o    (rs2addr_o),
    .valid_ro     (valid_ro),
    .ready_i      (ready_i),
    .pc_ro        (pc_ro),
    .inst_ro      (inst_ro),
    .rd_ro        (rd_ro),
    .rs1_ro       (rs1_ro),
    .rs2_ro       (rs2_ro),
    .funct3_ro    (funct3_ro),
    .funct7b5_ro  (funct7b5_ro),
    .imm_ro       (imm_ro),
    .class_ro     (class_ro),
    .rd_we_ro     (rd_we_ro)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] imm;
    logic [3:0]  cls;
    logic        we;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, act, exp);
    end
  endfunction

  function automatic exp_t model(logic [31:0] pc, logic [31:0] w);
    exp_t e;
    int op;
    int f3;
    int f7;
    int c;
    logic [31:0] ii;
    op = int'(w[6:0]);
    f3 = int'(w[14:12]);
    f7 = int'(w[31:25]);
    c  = 15;
    if (op == 'h33 && (f7 == 0 || (f7 == 32 && f3 inside {0, 5})))
      c = 0;
    else if (op == 'h13 && !(f3 == 1 && f7 != 0)
             && !(f3 == 5 && !(f7 inside {0, 32})))
      c = 1;
    else if (op == 'h03 && f3 inside {0, 1, 2, 4, 5})
      c = 2;
    else if (op == 'h23 && f3 inside {0, 1, 2})
      c = 3;
    else if (op == 'h63 && !(f3 inside {2, 3}))
      c = 4;
    else if (op == 'h6f)
      c = 5;
    else if (op == 'h67 && f3 == 0)
      c = 6;
    else if (op == 'h37)
      c = 7;
    else if (op == 'h17)
      c = 8;
    else if (op == 'h0f)
      c = 9;
    else if (op == 'h73)
      c = 10;
    ii = $signed(w) >>> 20;
    e.pc   = pc;
    e.inst = w;
    e.cls  = 4'(c);
    e.imm  = 32'b0;
    if (c inside {1, 2, 6, 10})
      e.imm = ii;
    else if (c == 3)
      e.imm = {ii[31:5], w[11:7]};
    else if (c == 4)
      e.imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
    else if (c inside {7, 8})
      e.imm = w & 32'hFFFFF000;
    else if (c == 5)
      e.imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
    e.we = (c inside {0, 1, 2, 5, 6, 7, 8}) && (w[11:7] != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] gen();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 13);
    case (k)
      0:  w[6:0] = 7'h33;
      1:  w[6:0] = 7'h13;
      2:  w[6:0] = 7'h03;
      3:  w[6:0] = 7'h23;
      4:  w[6:0] = 7'h63;
      5:  w[6:0] = 7'h6f;
      6:  w[6:0] = 7'h67;
      7:  w[6:0] = 7'h37;
      8:  w[6:0] = 7'h17;
      9:  w[6:0] = 7'h0f;
      10: w[6:0] = 7'h73;
      default: ;
    endcase
    if ($urandom_range(0, 1) == 1)
      w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    if ($urandom_range(0, 3) == 0)
      w[14:12] = 3'($urandom_range(0, 7));
    return w;
  endfunction

  task automatic chk_zero(string tag);
    chk({tag, "_valid"}, valid_ro, 0);
    chk({tag, "_pc"}, pc_ro, 0);
    chk({tag, "_inst"}, inst_ro, 0);
    chk({tag, "_rd"}, rd_ro, 0);
    chk({tag, "_rs1"}, rs1_ro, 0);
    chk({tag, "_rs2"}, rs2_ro, 0);
    chk({tag, "_f3"}, funct3_ro, 0);
    chk({tag, "_f7b5"}, funct7b5_ro, 0);
    chk({tag, "_imm"}, imm_ro, 0);
    chk({tag, "_class"}, class_ro, 0);
    chk({tag, "_rdwe"}, rd_we_ro, 0);
  endtask

  // One cycle of stimulus; entered and left at posedge+1
  task automatic step(input logic v, input logic [31:0] w,
                      input logic r, input logic j);
    logic acc;
    exp_t e;
    valid_i      = v;
    inst_i       = w;
    pc_i         = $urandom & 32'hFFFFFFFC;
    ready_i      = r;
    jump_taken_i = j;
    e = model(pc_i, w);
    #3;
    acc = v & ~j & ready_o;
    @(posedge clk);
    #1;
    if (acc)
      q.push_back(e);
  endtask

  // Monitor: compare the presented output with the scoreboard head
  always @(negedge clk) begin
    if (rst_n) begin
      chk("rs1addr", rs1addr_o, inst_i[19:15]);
      chk("rs2addr", rs2addr_o, inst_i[24:20]);
      chk("ready_o", ready_o,
          (q.size() == 0) | ready_i | jump_taken_i);
      if (q.size() == 0) begin
        chk("valid_idle", valid_ro, 0);
      end else begin
        chk("valid", valid_ro, 1);
        chk("pc", pc_ro, q[0].pc);
        chk("inst", inst_ro, q[0].inst);
        chk("rd", rd_ro, q[0].inst[11:7]);
        chk("rs1", rs1_ro, q[0].inst[19:15]);
        chk("rs2", rs2_ro, q[0].inst[24:20]);
        chk("funct3", funct3_ro, q[0].inst[14:12]);
        chk("funct7b5", funct7b5_ro, q[0].inst[30]);
        chk("imm", imm_ro, q[0].imm);
        chk("class", class_ro, q[0].cls);
        chk("rd_we", rd_we_ro, q[0].we);
        if (ready_i | jump_taken_i)
          void'(q.pop_front());
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    valid_i      = 1'b1;
    inst_i       = 32'h00500093;
    pc_i         = 32'h0000_0100;
    ready_i      = 1'b1;
    jump_taken_i = 1'b0;
    #2;
    chk_zero("rst0");
    @(posedge clk);
    #1;
    chk_zero("rst1");
    rst_n = 1'b1;

    step(1'b1, 32'h00500093, 1'b1, 1'b0);
    chk("first_valid", valid_ro, 1);
    chk("first_class", class_ro, 1);
    chk("first_rd", rd_ro, 1);
    chk("first_imm", imm_ro, 32'h5);
    chk("first_rdwe", rd_we_ro, 1);

    step(1'b1, 32'hFE20AE23, 1'b1, 1'b0);
    step(1'b1, 32'hFE000CE3, 1'b1, 1'b0);
    step(1'b1, 32'h123452B7, 1'b1, 1'b0);
    step(1'b1, 32'h00000000, 1'b1, 1'b0);
    step(1'b1, 32'h40001013, 1'b1, 1'b0);
    step(1'b1, 32'h40000033, 1'b1, 1'b0);

    for (int i = 0; i < 5; i++)
      step(1'b1, gen(), 1'b0, 1'b0);
    chk("stall_ready", ready_o, 0);
    step(1'b1, 32'h00208133, 1'b1, 1'b0);
    step(1'b1, 32'h00C00513, 1'b1, 1'b0);

    step(1'b1, 32'h00A00593, 1'b0, 1'b0);
    step(1'b1, 32'h00B00613, 1'b0, 1'b1);
    chk("flush_valid", valid_ro, 0);
    step(1'b0, gen(), 1'b1, 1'b0);

    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 9) < 8, gen(),
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 19) == 0);

    step(1'b1, 32'h00500093, 1'b1, 1'b0);
    step(1'b1, 32'h00600113, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("arst");
    q.delete();
    @(posedge clk);
    #1;
    chk_zero("arst_hold");
    valid_i = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++)
      step(1'b0, gen(), 1'b1, 1'b0);
    chk("post_rst_valid", valid_ro, 0);

    for (int i = 0; i < 100; i++)
      step($urandom_range(0, 9) < 8, gen(),
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 19) == 0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
